// File: rtl/instr_fetch_stage_if.sv
// Bundle of signals between the instruction fetch stage and its surroundings.
// These signals are grouped here:
//   - the instruction memory bus: imem_addr, imem_rdata
//   - the hazard and branch controls: stall, redirect, redirect_kind,
//     redirect_pc, redirect_imm, redirect_reg
//   - the IF/ID register towards decode: ifid_valid, ifid_instr, ifid_pc,
//     ifid_pc_plus4
//   - the performance counters: perf_fetched, perf_bubbles
// Modport master: the fetch stage itself.
// Modport slave: the environment (imem, hazard unit, branch resolution, decode).
interface instr_fetch_stage_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [1:0]  redirect_kind;
  logic [63:0] redirect_pc;
  logic [25:0] redirect_imm;
  logic [63:0] redirect_reg;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic [63:0] ifid_pc_plus4;
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  redirect,
    input  redirect_kind,
    input  redirect_pc,
    input  redirect_imm,
    input  redirect_reg,
    output ifid_valid,
    output ifid_instr,
    output ifid_pc,
    output ifid_pc_plus4,
    output perf_fetched,
    output perf_bubbles
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output redirect,
    output redirect_kind,
    output redirect_pc,
    output redirect_imm,
    output redirect_reg,
    input  ifid_valid,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  perf_fetched,
    input  perf_bubbles
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Holds the PC, presents it to instruction memory, and captures the returned
// instruction with its PC and PC+4 into IF/ID. A taken branch (redirect)
// loads the computed target into the PC and a bubble into IF/ID. A stall
// holds both the PC and IF/ID. A redirect takes priority over a stall.
// Ports:
//   clk   - single clock; all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - instr_fetch_stage_if.master (imem bus, stall/redirect controls,
//           IF/ID outputs, performance counters)
// Parameter:
//   RESET_PC - PC value loaded on reset
// Optional feature macro:
//   IF_PERF_CNT_EN - when defined, builds saturating counters for fetched
//                    instructions and delivered bubbles; otherwise both
//                    counter outputs are constant zero.
module instr_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    RST  = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_r;
  logic [63:0] pc_r;
  logic        ifid_valid_r;
  logic [31:0] ifid_instr_r;
  logic [63:0] ifid_pc_r;
  logic [63:0] ifid_pc_plus4_r;

  logic [63:0] pc_plus4_s;
  logic [63:0] target_s;
  logic [63:0] cb_off_s;
  logic [63:0] b_off_s;

  // Sign-extended, word-scaled branch offsets. The shift is folded into the concatenation.
  assign cb_off_s   = {{43{bus.redirect_imm[18]}}, bus.redirect_imm[18:0], 2'b00};
  assign b_off_s    = {{36{bus.redirect_imm[25]}}, bus.redirect_imm[25:0], 2'b00};
  // All PC arithmetic wraps modulo 2^64.
  assign pc_plus4_s = pc_r + 64'd4;

  // Redirect target selection by branch kind
  always_comb begin
    target_s = bus.redirect_pc + 64'd4;
    case (bus.redirect_kind)
      2'b00:   target_s = bus.redirect_pc + cb_off_s;
      2'b01:   target_s = bus.redirect_pc + b_off_s;
      2'b10:   target_s = bus.redirect_reg;
      2'b11:   target_s = bus.redirect_pc + 64'd4;
      default: target_s = bus.redirect_pc + 64'd4;
    endcase
  end

  // PC, IF/ID register and fetch FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= RST;
      pc_r            <= RESET_PC;
      ifid_valid_r    <= 1'b0;
      ifid_instr_r    <= 32'h0;
      ifid_pc_r       <= 64'h0;
      ifid_pc_plus4_r <= 64'h0;
    end else begin
      case (state_r)
        RST, RUN, HOLD: begin
          if (bus.redirect) begin
            // Bubble: the PC fields keep their previous values.
            pc_r         <= target_s;
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= 32'h0;
            state_r      <= RUN;
          end else if (bus.stall) begin
            state_r <= HOLD;
          end else begin
            pc_r            <= pc_plus4_s;
            ifid_valid_r    <= 1'b1;
            ifid_instr_r    <= bus.imem_rdata;
            ifid_pc_r       <= pc_r;
            ifid_pc_plus4_r <= pc_plus4_s;
            state_r         <= RUN;
          end
        end
        default: begin
          state_r <= RST;
        end
      endcase
    end
  end

  assign bus.imem_addr     = pc_r;
  assign bus.ifid_valid    = ifid_valid_r;
  assign bus.ifid_instr    = ifid_instr_r;
  assign bus.ifid_pc       = ifid_pc_r;
  assign bus.ifid_pc_plus4 = ifid_pc_plus4_r;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_bubbles_r;
  logic        load_valid_s;
  logic        load_bubble_s;

  assign load_bubble_s = bus.redirect;
  assign load_valid_s  = !bus.redirect && !bus.stall;

  // Saturating counters of instructions and bubbles loaded into IF/ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_r <= 32'h0;
      perf_bubbles_r <= 32'h0;
    end else begin
      if (load_valid_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end else begin
        perf_fetched_r <= perf_fetched_r;
      end
      if (load_bubble_s && (perf_bubbles_r != 32'hFFFF_FFFF)) begin
        perf_bubbles_r <= perf_bubbles_r + 32'd1;
      end else begin
        perf_bubbles_r <= perf_bubbles_r;
      end
    end
  end

  assign bus.perf_fetched = perf_fetched_r;
  assign bus.perf_bubbles = perf_bubbles_r;
`else
  assign bus.perf_fetched = 32'h0;
  assign bus.perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed testbench for instr_fetch_stage with RESET_PC = 64'h40.
// The instruction memory model returns 32'hE000_0000 | addr[31:0].
module tb_instr_fetch_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  instr_fetch_stage_if bus ();

  instr_fetch_stage #(.RESET_PC(64'h40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_rdata = 32'hE000_0000 | bus.imem_addr[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                          input logic [63:0] pc, input logic [63:0] pc4, input logic [63:0] addr);
    chk({tag, ".valid"}, {63'h0, bus.ifid_valid}, {63'h0, v});
    chk({tag, ".instr"}, {32'h0, bus.ifid_instr}, {32'h0, ins});
    chk({tag, ".pc"}, bus.ifid_pc, pc);
    chk({tag, ".pc4"}, bus.ifid_pc_plus4, pc4);
    chk({tag, ".addr"}, bus.imem_addr, addr);
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] f, input logic [31:0] b);
`ifdef IF_PERF_CNT_EN
    chk({tag, ".fetched"}, {32'h0, bus.perf_fetched}, {32'h0, f});
    chk({tag, ".bubbles"}, {32'h0, bus.perf_bubbles}, {32'h0, b});
`else
    chk({tag, ".fetched"}, {32'h0, bus.perf_fetched}, {32'h0, f & 32'h0});
    chk({tag, ".bubbles"}, {32'h0, bus.perf_bubbles}, {32'h0, b & 32'h0});
`endif
  endtask

  task automatic set_redirect(input logic r, input logic [1:0] k, input logic [63:0] rpc,
                              input logic [25:0] imm, input logic [63:0] rreg);
    bus.redirect      = r;
    bus.redirect_kind = k;
    bus.redirect_pc   = rpc;
    bus.redirect_imm  = imm;
    bus.redirect_reg  = rreg;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.stall = 1'b0;
    set_redirect(1'b0, 2'b00, 64'h0, 26'h0, 64'h0);

    // Reset state
    #12;
    chk_ifid("reset", 1'b0, 32'h0, 64'h0, 64'h0, 64'h40);
    chk_perf("reset", 32'd0, 32'd0);
    rst_n = 1'b1;

    // Free-running fetch from RESET_PC
    step(); chk_ifid("run0", 1'b1, 32'hE000_0040, 64'h40, 64'h44, 64'h44);
    step(); chk_ifid("run1", 1'b1, 32'hE000_0044, 64'h44, 64'h48, 64'h48);
    step(); chk_ifid("run2", 1'b1, 32'hE000_0048, 64'h48, 64'h4C, 64'h4C);

    // Register redirect to 8 to set up the stall test
    set_redirect(1'b1, 2'b10, 64'h0, 26'h0, 64'h8);
    step(); chk_ifid("br8", 1'b0, 32'h0, 64'h48, 64'h4C, 64'h8);
    set_redirect(1'b0, 2'b00, 64'h0, 26'h0, 64'h0);
    step(); chk_ifid("at8", 1'b1, 32'hE000_0008, 64'h8, 64'hC, 64'hC);
    chk_perf("mid", 32'd4, 32'd1);

    // Stall for three edges
    bus.stall = 1'b1;
    step(); chk_ifid("stall0", 1'b1, 32'hE000_0008, 64'h8, 64'hC, 64'hC);
    step(); chk_ifid("stall1", 1'b1, 32'hE000_0008, 64'h8, 64'hC, 64'hC);
    step(); chk_ifid("stall2", 1'b1, 32'hE000_0008, 64'h8, 64'hC, 64'hC);
    chk_perf("stall", 32'd4, 32'd1);
    bus.stall = 1'b0;
    step(); chk_ifid("unstall", 1'b1, 32'hE000_000C, 64'hC, 64'h10, 64'h10);

    // CB redirect, offset -2 words
    set_redirect(1'b1, 2'b00, 64'h100, 26'h007FFFE, 64'h0);
    step(); chk_ifid("cb", 1'b0, 32'h0, 64'hC, 64'h10, 64'hF8);
    set_redirect(1'b0, 2'b00, 64'h0, 26'h0, 64'h0);
    step(); chk_ifid("cb_tgt", 1'b1, 32'hE000_00F8, 64'hF8, 64'hFC, 64'hFC);

    // B redirect, offset +16 words
    set_redirect(1'b1, 2'b01, 64'h100, 26'h10, 64'h0);
    step(); chk_ifid("b", 1'b0, 32'h0, 64'hF8, 64'hFC, 64'h140);
    set_redirect(1'b0, 2'b00, 64'h0, 26'h0, 64'h0);
    step(); chk_ifid("b_tgt", 1'b1, 32'hE000_0140, 64'h140, 64'h144, 64'h144);

    // Redirect together with stall: redirect wins
    bus.stall = 1'b1;
    set_redirect(1'b1, 2'b10, 64'h0, 26'h0, 64'h2000);
    step(); chk_ifid("br_stall", 1'b0, 32'h0, 64'h140, 64'h144, 64'h2000);
    set_redirect(1'b0, 2'b00, 64'h0, 26'h0, 64'h0);
    step(); chk_ifid("br_hold", 1'b0, 32'h0, 64'h140, 64'h144, 64'h2000);
    bus.stall = 1'b0;
    step(); chk_ifid("br_tgt", 1'b1, 32'hE000_2000, 64'h2000, 64'h2004, 64'h2004);

    // Reserved kind goes to redirect_pc + 4; then back-to-back redirect to the wrap point
    set_redirect(1'b1, 2'b11, 64'h300, 26'h3FFFFFF, 64'h0);
    step(); chk_ifid("rsvd", 1'b0, 32'h0, 64'h2000, 64'h2004, 64'h304);
    set_redirect(1'b1, 2'b10, 64'h0, 26'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    step(); chk_ifid("wrap_br", 1'b0, 32'h0, 64'h2000, 64'h2004, 64'hFFFF_FFFF_FFFF_FFFC);
    set_redirect(1'b0, 2'b00, 64'h0, 26'h0, 64'h0);
    step(); chk_ifid("wrap0", 1'b1, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0);
    step(); chk_ifid("wrap1", 1'b1, 32'hE000_0000, 64'h0, 64'h4, 64'h4);
    chk_perf("wrap", 32'd10, 32'd6);

    // Asynchronous reset in the middle of a stall
    bus.stall = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    chk_ifid("async_rst", 1'b0, 32'h0, 64'h0, 64'h0, 64'h40);
    chk_perf("async_rst", 32'd0, 32'd0);
    bus.stall = 1'b0;
    #2;
    rst_n = 1'b1;

    // Five fetches plus one redirect
    step(); step(); step(); step(); step();
    chk_ifid("refetch", 1'b1, 32'hE000_0050, 64'h50, 64'h54, 64'h54);
    set_redirect(1'b1, 2'b11, 64'h0, 26'h0, 64'h0);
    step(); chk_ifid("final_br", 1'b0, 32'h0, 64'h50, 64'h54, 64'h4);
    set_redirect(1'b0, 2'b00, 64'h0, 26'h0, 64'h0);
    chk_perf("final", 32'd5, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 5-stage pipelined CPU. Holds the PC, drives the instruction memory address, captures the returned instruction with its PC and PC+4 into IF/ID, and applies stalls from the hazard unit and taken-branch redirects from the later stages. It computes redirect targets from raw CB/B offset fields, BR register values or the branch PC. It sits directly upstream of decode (control unit, register file, extenders).

## Interface
- RESET_PC, 64'h0, PC value loaded on reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  64  current PC; imem returns data combinationally in the same cycle.
- imem_rdata  in  32  instruction at imem_addr.
- stall  in  1  hold PC and IF/ID.
- redirect  in  1  taken branch resolved this cycle.
- redirect_kind  in  2  00 conditional (CB, 19-bit offset), 01 unconditional (B/BL, 26-bit offset), 10 register (BR), 11 reserved.
- redirect_pc  in  64  PC of the branch instruction.
- redirect_imm  in  26  raw offset field; CB uses [18:0].
- redirect_reg  in  64  register target for BR.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  instruction; 32'h0 when not valid.
- ifid_pc  out  64  PC of ifid_instr.
- ifid_pc_plus4  out  64  ifid_pc + 4, the BL link value.
- perf_fetched  out  32  valid instructions delivered.
- perf_bubbles  out  32  bubbles delivered.

## Operation
- FSM states: RST (rst_n low), RUN, HOLD.
- RST: pc = RESET_PC, ifid_valid = 0, ifid_instr = 0, ifid_pc = 0, ifid_pc_plus4 = 0, counters = 0. The first edge after rst_n rises enters RUN and fetches from RESET_PC.
- Every edge uses this priority:
  - redirect = 1: pc <= target, IF/ID <= bubble (valid 0, instr 0, pc fields hold), state <= RUN. Redirect overrides stall.
  - stall = 1: pc and IF/ID hold; state <= HOLD.
  - otherwise: IF/ID <= {1, imem_rdata, pc, pc+4}, pc <= pc+4, state <= RUN.
- Targets:
  - kind 00: redirect_pc + (sext(redirect_imm[18:0]) << 2).
  - kind 01: redirect_pc + (sext(redirect_imm[25:0]) << 2).
  - kind 10: redirect_reg, used unmodified with no alignment.
  - kind 11: redirect_pc + 4.
- Arithmetic: all additions are 64-bit modulo 2^64 and wrap silently, e.g. 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Counters: perf_fetched increments on each edge that loads a valid instruction. perf_bubbles increments on each edge that loads a bubble. Both saturate at 32'hFFFF_FFFF, and neither changes on held (stall) edges.

## Timing
- imem_addr = pc combinationally. Fetch-to-IF/ID latency is one edge.
- Redirect penalty: the edge that sees redirect loads a bubble. The target instruction appears in IF/ID one edge later, or later if stall is asserted then.
- Stall is level-sensitive. N stalled cycles hold the IF/ID contents N edges with no loss or duplication.
- rst_n falling forces the RST values asynchronously, mid-stall or mid-redirect included. Deassertion is assumed synchronised externally.
- Outputs are registered except imem_addr.

## Configuration
- IF_PERF_CNT_EN defined: perf_fetched and perf_bubbles count as described.
- IF_PERF_CNT_EN undefined: the counter registers are not built, and both ports are constant 32'h0.

## Test plan
- Reset with RESET_PC = 64'h40, release, 3 free edges -> ifid_pc goes 40, 44, 48; ifid_valid is 1 from the first edge; ifid_pc_plus4 = ifid_pc + 4.
- stall high for 3 edges while ifid_pc = 64'h8 -> ifid_pc and imem_addr unchanged. Release -> ifid_pc = 64'h8 → 64'hC, with no skipped or duplicated PC.
- redirect kind 00, redirect_pc = 64'h100, imm[18:0] = 19'h7FFFE (-2) -> next imem_addr = 64'hF8, one bubble, then ifid_pc = 64'hF8. Kind 01 with imm = 26'h10 -> target 64'h140.
- redirect and stall asserted together, kind 10, redirect_reg = 64'h2000 -> pc = 64'h2000, bubble in IF/ID. Release stall -> ifid_pc = 64'h2000.
- Wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, then run 2 edges -> ifid_pc goes ...FFFC then 64'h0.
- rst_n asserted mid-stall -> all outputs at reset values immediately. With IF_PERF_CNT_EN, 5 fetches plus 1 redirect give perf_fetched = 5 and perf_bubbles = 1.
